// File: rtl/spi_note_sched.sv
// SPI-fed note queue and tone scheduler: packets {duration, period} are queued and played in order.
// Build option: define NOTE_GAP_EN to insert GAP_CYC silent cycles after every note.
module spi_note_sched #(
    parameter int DUR_UNIT = 50000,
    parameter int DEPTH    = 4,
    parameter int GAP_CYC  = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   sck,
    input  logic                   sdi,
    output logic [15:0]            tone_period,
    output logic                   tone_en,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   err_frame,
    output logic                   err_ovf
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PLAY_W = $clog2(255 * DUR_UNIT + 1);
`ifdef NOTE_GAP_EN
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;
`endif

    logic              cs_meta_r, cs_sync_r, cs_prev_r;
    logic              sck_meta_r, sck_sync_r, sck_prev_r;
    logic              sdi_meta_r, sdi_sync_r;
    logic [23:0]       shift_r;
    logic [4:0]        bit_cnt_r;
    logic [23:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    logic [PLAY_W-1:0] play_cnt_r;
`ifdef NOTE_GAP_EN
    logic [GAP_W-1:0]  gap_cnt_r;
`endif
    logic [15:0]       period_r;
    logic              tone_en_r, err_frame_r, err_ovf_r;

    logic              cs_rise_s, cs_fall_s, sck_rise_s, frame_ok_s, full_s;
    logic              push_req_s, flush_s, pop_s, push_s, ovf_s, avail_s;
    logic [23:0]       head_s;
    logic [PLAY_W-1:0] play_load_s;

    // Edge detection and end-of-frame decode into push/flush/overflow strobes
    always_comb begin
        cs_rise_s   = cs_sync_r & ~cs_prev_r;
        cs_fall_s   = ~cs_sync_r & cs_prev_r;
        sck_rise_s  = sck_sync_r & ~sck_prev_r;
        frame_ok_s  = cs_fall_s && (bit_cnt_r == 5'd24);
        full_s      = (count_r == CNT_W'(DEPTH));
        push_req_s  = frame_ok_s && (shift_r[23:16] != 8'd0);
        flush_s     = frame_ok_s && (shift_r[23:16] == 8'd0);
        pop_s       = (state_r == LOAD) && !flush_s;
        // a pop in the same cycle frees the slot, so a full queue still accepts
        push_s      = push_req_s && (!full_s || pop_s);
        ovf_s       = push_req_s && full_s && !pop_s;
        avail_s     = (count_r != {CNT_W{1'b0}}) || push_s;
        head_s      = mem_r[rd_ptr_r];
        play_load_s = PLAY_W'(head_s[23:16]) * PLAY_W'(DUR_UNIT) - PLAY_W'(1);
    end

    // Two-flop synchronizers plus one history flop each for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_meta_r  <= 1'b0; cs_sync_r  <= 1'b0; cs_prev_r  <= 1'b0;
            sck_meta_r <= 1'b0; sck_sync_r <= 1'b0; sck_prev_r <= 1'b0;
            sdi_meta_r <= 1'b0; sdi_sync_r <= 1'b0;
        end else begin
            cs_meta_r  <= cs;  cs_sync_r  <= cs_meta_r;  cs_prev_r  <= cs_sync_r;
            sck_meta_r <= sck; sck_sync_r <= sck_meta_r; sck_prev_r <= sck_sync_r;
            sdi_meta_r <= sdi; sdi_sync_r <= sdi_meta_r;
        end
    end

    // Serial shift register and saturating bit counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_r   <= 24'd0;
            bit_cnt_r <= 5'd0;
        end else if (cs_rise_s) begin
            bit_cnt_r <= 5'd0;
        end else if (sck_rise_s && cs_sync_r) begin
            shift_r <= {shift_r[22:0], sdi_sync_r};
            if (bit_cnt_r != 5'd25) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
        end
    end

    // Note queue storage, pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 24'd0;
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            err_frame_r <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else if (flush_s) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            err_frame_r <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
            if (cs_fall_s && !frame_ok_s) begin
                err_frame_r <= 1'b1;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    // Scheduler: load the head note, play it for its duration, optionally rest
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            play_cnt_r <= {PLAY_W{1'b0}};
            period_r   <= 16'd0;
            tone_en_r  <= 1'b0;
`ifdef NOTE_GAP_EN
            gap_cnt_r  <= {GAP_W{1'b0}};
`endif
        end else if (flush_s) begin
            state_r   <= IDLE;
            tone_en_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (avail_s) begin
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    period_r   <= head_s[15:0];
                    tone_en_r  <= (head_s[15:0] != 16'd0);
                    play_cnt_r <= play_load_s;
                    state_r    <= PLAY;
                end
                PLAY: begin
                    if (play_cnt_r == {PLAY_W{1'b0}}) begin
                        tone_en_r <= 1'b0;
`ifdef NOTE_GAP_EN
                        gap_cnt_r <= GAP_W'(GAP_CYC - 1);
                        state_r   <= GAP;
`else
                        state_r   <= avail_s ? LOAD : IDLE;
`endif
                    end else begin
                        play_cnt_r <= play_cnt_r - PLAY_W'(1);
                    end
                end
`ifdef NOTE_GAP_EN
                GAP: begin
                    if (gap_cnt_r == {GAP_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
`endif
                default: state_r <= IDLE;
            endcase
        end
    end

    assign tone_period = period_r;
    assign tone_en     = tone_en_r;
    assign q_count     = count_r;
    assign err_frame   = err_frame_r;
    assign err_ovf     = err_ovf_r;
    assign busy        = (state_r != IDLE) || (count_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_spi_note_sched.sv
// Scoreboard bench for spi_note_sched: a packet-level model queues expected notes, a monitor checks them.
module tb_spi_note_sched;
    localparam int DUR_UNIT = 10;
    localparam int DEPTH    = 4;
    localparam int GAP_CYC  = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef NOTE_GAP_EN
    localparam int TAIL      = GAP_CYC;      // silent busy cycles after a note
    localparam int CHAIN_LOW = GAP_CYC + 2;  // gap, idle, load between queued notes
`else
    localparam int TAIL      = 0;
    localparam int CHAIN_LOW = 1;            // load only
`endif

    logic clk = 1'b0, reset = 1'b0, cs = 1'b0, sck = 1'b0, sdi = 1'b0;
    logic [15:0]   tone_period;
    logic          tone_en, busy, err_frame, err_ovf;
    logic [CW-1:0] q_count;

    int checks = 0;
    int errors = 0;

    typedef struct {logic [15:0] period; int len; int pre_low;} note_t;
    note_t       sb[$];   // audible notes expected on tone_en, in order
    logic [23:0] mq[$];   // model of notes waiting in the hardware queue
    bit          m_ef = 1'b0, m_eo = 1'b0;

    always #5 clk = ~clk;

    spi_note_sched #(.DUR_UNIT(DUR_UNIT), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdi(sdi),
        .tone_period(tone_period), .tone_en(tone_en), .busy(busy),
        .q_count(q_count), .err_frame(err_frame), .err_ovf(err_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Packet-level reference: framing, flush, queue capacity
    function automatic void model_packet(input logic [23:0] d, input int nbits, input bit chk_len,
                                         input int pre_low);
        note_t n;
        if (nbits != 24) begin
            m_ef = 1'b1;
        end else if (d[23:16] == 8'd0) begin
            mq.delete();
            sb.delete();
            m_ef = 1'b0;
            m_eo = 1'b0;
        end else if (mq.size() < DEPTH) begin
            mq.push_back(d);
            if (d[15:0] != 16'd0) begin
                n.period  = d[15:0];
                n.len     = chk_len ? int'(d[23:16]) * DUR_UNIT : 0;
                n.pre_low = pre_low;
                sb.push_back(n);
            end
        end else begin
            m_eo = 1'b1;
        end
    endfunction

    task automatic spi_send(input logic [23:0] d, input int nbits);
        logic [23:0] sh;
        sh = d;
        cs = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = sh[23];
            sh  = {sh[22:0], 1'b0};
            repeat (3) @(negedge clk);
            sck = 1'b1;
            repeat (3) @(negedge clk);
            sck = 1'b0;
        end
        repeat (3) @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((busy || tone_en) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || tone_en) begin
            errors++;
            $display("FAIL %s timeout busy=%0b tone_en=%0b required idle", name, busy, tone_en);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_period"}, tone_period, 16'd0);
        chk({name, "_tone_en"}, tone_en, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_q_count"}, q_count, 0);
        chk({name, "_err_frame"}, err_frame, 1'b0);
        chk({name, "_err_ovf"}, err_ovf, 1'b0);
    endtask

    // Monitor: every tone_en rise pops the scoreboard; checks period, spacing, length
    initial begin
        note_t cur;
        bit    te_prev, active;
        int    hi_cnt, lo_cnt;
        te_prev = 1'b0; active = 1'b0; hi_cnt = 0; lo_cnt = 0;
        cur.period = 16'd0; cur.len = 0; cur.pre_low = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                te_prev = 1'b0; active = 1'b0; hi_cnt = 0; lo_cnt = 0;
            end else begin
                if (tone_en && !te_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_note period=%0h required no note", tone_period);
                        active = 1'b0;
                    end else begin
                        cur = sb.pop_front();
                        active = 1'b1;
                        chk("note_period", tone_period, cur.period);
                        if (cur.pre_low != 0) chk("note_spacing", lo_cnt, cur.pre_low);
                    end
                    hi_cnt = 1;
                end else if (tone_en) begin
                    hi_cnt++;
                end else if (te_prev) begin
                    if (active && cur.len != 0) chk("note_len", hi_cnt, cur.len);
                    lo_cnt = 1;
                end else begin
                    lo_cnt++;
                end
                te_prev = tone_en;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d;
        logic [15:0] per;
        int          nb;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // single note, exact timeline from end of frame
        spi_send(24'h0114FF, 24);
        model_packet(24'h0114FF, 24, 1'b1, 0);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            chk("basic_tone_en", tone_en, (i >= 4 && i <= 13));
            chk("basic_busy", busy, (i >= 3 && i <= 13 + TAIL));
            if (i == 3) chk("basic_q_count", q_count, 1);
            if (i == 4) chk("basic_period", tone_period, 16'h14FF);
        end
        mq.delete();

        // randomized notes, rests and malformed frames
        for (int r = 0; r < 10; r++) begin
            per = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            d   = {8'($urandom_range(1, 3)), per};
            nb  = 24;
            if ($urandom_range(0, 4) == 0) begin
                nb = $urandom_range(1, 30);
                if (nb == 24) nb = 23;
            end
            spi_send(d, nb);
            model_packet(d, nb, 1'b1, 0);
            wait_idle(200, "rand_idle");
            mq.delete();
            chk("rand_err_frame", err_frame, m_ef);
            chk("rand_err_ovf", err_ovf, m_eo);
            chk("rand_q_count", q_count, mq.size());
        end

        // long note, then overfill the queue while it plays
        spi_send(24'hFF0100, 24);
        model_packet(24'hFF0100, 24, 1'b0, 0);
        repeat (4) @(negedge clk);
        void'(mq.pop_front());
        chk("long_started", tone_en, 1'b1);
        for (int k = 0; k < 5; k++) begin
            d = {8'($urandom_range(1, 255)), 16'($urandom_range(1, 65535))};
            spi_send(d, 24);
            model_packet(d, 24, 1'b1, 0);
            repeat (4) @(negedge clk);
        end
        chk("ovf_q_count", q_count, mq.size());
        chk("ovf_flag", err_ovf, m_eo);
        chk("ovf_still_playing", tone_en, 1'b1);

        // flush while playing: silence on the edge after the frame ends
        spi_send(24'h000000, 24);
        model_packet(24'h000000, 24, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("flush_pre_tone_en", tone_en, 1'b1);
        @(negedge clk);
        chk("flush_tone_en", tone_en, 1'b0);
        chk("flush_q_count", q_count, mq.size());
        chk("flush_err_ovf", err_ovf, m_eo);
        chk("flush_err_frame", err_frame, m_ef);
        chk("flush_busy", busy, 1'b0);
        repeat (5) @(negedge clk);

        // two short notes queued behind a long one: spacing checked by the monitor
        spi_send(24'h300123, 24);
        model_packet(24'h300123, 24, 1'b1, 0);
        repeat (4) @(negedge clk);
        void'(mq.pop_front());
        for (int k = 0; k < 2; k++) begin
            d = {8'h01, 16'($urandom_range(1, 65535))};
            spi_send(d, 24);
            model_packet(d, 24, 1'b1, CHAIN_LOW);
            repeat (4) @(negedge clk);
        end
        chk("chain_q_count", q_count, mq.size());
        wait_idle(1500, "chain_idle");
        mq.delete();

        // truncated frame
        spi_send(24'h02ABCD, 20);
        model_packet(24'h02ABCD, 20, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("short_err_frame", err_frame, m_ef);
        chk("short_q_count", q_count, 0);
        chk("short_tone_en", tone_en, 1'b0);

        // rest note keeps busy high, then reset aborts it
        spi_send(24'h030000, 24);
        model_packet(24'h030000, 24, 1'b1, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i >= 3) chk("rest_busy", busy, 1'b1);
            chk("rest_tone_en", tone_en, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        mq.delete();
        m_ef = 1'b0;
        m_eo = 1'b0;
        chk_all_zero("midnote_reset");
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_err_frame", err_frame, m_ef);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
